// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver
//   Time-multiplexed hexadecimal driver for N_DIGITS seven-segment digits.
//   A free-running prescaler gives each digit a slot of DIV clocks. The first
//   clock of every slot is a guard cycle with everything dark, which
//   suppresses ghosting while the anode lines switch. New values are captured
//   into a pending register on load and are committed to the display register
//   only at the frame wrap, so a frame never shows a torn value.
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-high reset
//   value       hex nibbles, nibble i = value[4i+3:4i], digit 0 least significant
//   dp_in       decimal point request per digit
//   load        capture value/dp_in into the pending register
//   blank_mask  1 = force digit i blank (live, not latched)
//   lz_en       leading-zero blanking enable (live)
//   seg         segments {g,f,e,d,c,b,a}, registered
//   dp          decimal point, registered
//   an          one-hot digit enable, registered
//   frame_done  one-cycle pulse after every frame commit
module sseg_scan_driver #(
  parameter int N_DIGITS       = 4,
  parameter int DIV            = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  load,
  input  logic [N_DIGITS-1:0]   blank_mask,
  input  logic                  lz_en,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_done
);

  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  // Active-high lit pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h67;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h58;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h7B;
      4'hF: pat = 7'h71;
      default: pat = 7'h00;
    endcase
    return pat;
  endfunction

  // The only polarity transform in the block: internal logic is active-high.
  function automatic logic [6:0] seg_pol(input logic [6:0] s);
    return SEG_ACTIVE_LOW ? ~s : s;
  endfunction

  function automatic logic dp_pol(input logic d);
    return SEG_ACTIVE_LOW ? ~d : d;
  endfunction

  function automatic logic [N_DIGITS-1:0] an_pol(input logic [N_DIGITS-1:0] a);
    return AN_ACTIVE_LOW ? ~a : a;
  endfunction

  // Scan and data state.
  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [4*N_DIGITS-1:0] pending;
  logic [N_DIGITS-1:0]   pending_dp;
  logic [4*N_DIGITS-1:0] display;
  logic [N_DIGITS-1:0]   display_dp;

  logic                  tick;
  logic                  commit;
  logic [CNT_W-1:0]      cnt_nxt;
  logic [IDX_W-1:0]      idx_nxt;
  logic [4*N_DIGITS-1:0] pending_nxt;
  logic [N_DIGITS-1:0]   pending_dp_nxt;
  logic [4*N_DIGITS-1:0] display_nxt;
  logic [N_DIGITS-1:0]   display_dp_nxt;

  always_comb begin
    tick   = (cnt == CNT_LAST);
    commit = tick && (idx == IDX_LAST);

    cnt_nxt = tick ? '0 : cnt + CNT_W'(1);
    idx_nxt = idx;
    if (tick) begin
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end

    pending_nxt    = load ? value : pending;
    pending_dp_nxt = load ? dp_in : pending_dp;

    // On a coincident load the display still takes the old pending; the new
    // data waits for the next frame wrap.
    display_nxt    = commit ? pending    : display;
    display_dp_nxt = commit ? pending_dp : display_dp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      pending    <= '0;
      pending_dp <= '0;
      display    <= '0;
      display_dp <= '0;
    end else begin
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      pending    <= pending_nxt;
      pending_dp <= pending_dp_nxt;
      display    <= display_nxt;
      display_dp <= display_dp_nxt;
    end
  end

  // Leading-zero blanking: walk from the most significant digit down while
  // the nibbles seen so far are all zero. Digit 0 is never blanked this way.
  logic [N_DIGITS-1:0] lz_blank;
  logic                zero_run;

  always_comb begin
    lz_blank = '0;
    zero_run = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run    = zero_run && (display_nxt[4*i +: 4] == 4'h0);
      lz_blank[i] = lz_en && (i != 0) && zero_run;
    end
  end

  // Output selection is done from the post-edge state so the registered
  // outputs line up with the registered cnt/idx in the same cycle.
  logic [3:0]          sel_nib;
  logic                sel_dp;
  logic                sel_blank;
  logic [N_DIGITS-1:0] an_hot;
  logic                guard;
  logic [6:0]          seg_hi;
  logic                dp_hi;
  logic [N_DIGITS-1:0] an_hi;

  always_comb begin
    sel_nib   = 4'h0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    an_hot    = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_nxt == IDX_W'(i)) begin
        sel_nib   = display_nxt[4*i +: 4];
        sel_dp    = display_dp_nxt[i];
        sel_blank = blank_mask[i] || lz_blank[i];
        an_hot[i] = 1'b1;
      end
    end

    guard = (cnt_nxt == '0);

    // A blank digit keeps its anode slot so every digit has equal duty.
    seg_hi = (guard || sel_blank) ? 7'h00 : hex7(sel_nib);
    dp_hi  = !guard && !sel_blank && sel_dp;
    an_hi  = guard ? '0 : an_hot;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= seg_pol(7'h00);
      dp         <= dp_pol(1'b0);
      an         <= an_pol('0);
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_pol(seg_hi);
      dp         <= dp_pol(dp_hi);
      an         <= an_pol(an_hi);
      frame_done <= commit;
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
module tb_sseg_scan_driver;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic [3:0]  blank_mask;
  logic        lz_en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  sseg_scan_driver #(
    .N_DIGITS      (4),
    .DIV           (4),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .value     (value),
    .dp_in     (dp_in),
    .load      (load),
    .blank_mask(blank_mask),
    .lz_en     (lz_en),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Active-low patterns.
  localparam logic [6:0] S_OFF = 7'h7F;
  localparam logic [6:0] S_0   = 7'h40;
  localparam logic [6:0] S_1   = 7'h79;
  localparam logic [6:0] S_2   = 7'h24;
  localparam logic [6:0] S_5   = 7'h12;
  localparam logic [6:0] S_9   = 7'h18;
  localparam logic [6:0] S_A   = 7'h08;
  localparam logic [6:0] S_F   = 7'h0E;

  // Checks one full frame starting at the guard cycle of digit 0 and leaves
  // the bench at the guard cycle of the next frame. es holds digit d's seg at
  // [7d+6:7d]; edp the expected dp per digit; fd0 the frame_done expected in
  // the first cycle. With late_ld, value=late_v is loaded on the commit edge.
  task automatic frame_chk(input string nm, input logic [27:0] es, input logic [3:0] edp,
                           input logic fd0, input logic late_ld, input logic [15:0] late_v);
    logic [3:0] exp_an;
    int d;
    int c;
    for (int k = 0; k < 16; k++) begin
      d = k / 4;
      c = k % 4;
      if (c == 0) begin
        chk($sformatf("%s k%0d an_guard", nm, k), 32'(an), 32'hF);
        chk($sformatf("%s k%0d seg_guard", nm, k), 32'(seg), 32'(S_OFF));
        chk($sformatf("%s k%0d dp_guard", nm, k), 32'(dp), 32'h1);
      end else begin
        exp_an = 4'hF;
        exp_an[d] = 1'b0;
        chk($sformatf("%s k%0d an", nm, k), 32'(an), 32'(exp_an));
        chk($sformatf("%s k%0d seg", nm, k), 32'(seg), 32'(es[d*7 +: 7]));
        chk($sformatf("%s k%0d dp", nm, k), 32'(dp), 32'(edp[d]));
      end
      chk($sformatf("%s k%0d frame_done", nm, k), 32'(frame_done), (k == 0) ? 32'(fd0) : 32'h0);
      if (k == 15 && late_ld) begin
        value = late_v;
        load  = 1'b1;
      end
      step();
      load = 1'b0;
    end
  endtask

  initial begin
    rst        = 1'b1;
    value      = 16'h0000;
    dp_in      = 4'h0;
    load       = 1'b0;
    blank_mask = 4'h0;
    lz_en      = 1'b0;

    repeat (3) step();
    chk("rst an", 32'(an), 32'hF);
    chk("rst seg", 32'(seg), 32'(S_OFF));
    chk("rst dp", 32'(dp), 32'h1);
    chk("rst frame_done", 32'(frame_done), 32'h0);
    rst = 1'b0;

    // Power-up contents: all zeros, frame_done every 16 cycles.
    frame_chk("f1", {S_0, S_0, S_0, S_0}, 4'hF, 1'b0, 1'b0, 16'h0);
    value = 16'h1A2F;
    load  = 1'b1;
    frame_chk("f2", {S_0, S_0, S_0, S_0}, 4'hF, 1'b1, 1'b0, 16'h0);

    // 1A2F shown after the wrap; load 0005 for the next frame.
    value = 16'h0005;
    load  = 1'b1;
    frame_chk("f3", {S_1, S_A, S_2, S_F}, 4'hF, 1'b1, 1'b0, 16'h0);

    // Leading-zero blanking on, then off.
    lz_en = 1'b1;
    frame_chk("f4", {S_OFF, S_OFF, S_OFF, S_5}, 4'hF, 1'b1, 1'b0, 16'h0);
    lz_en = 1'b0;
    value = 16'h1111;
    load  = 1'b1;
    frame_chk("f5", {S_0, S_0, S_0, S_5}, 4'hF, 1'b1, 1'b1, 16'h9999);

    // Load on the commit edge: old pending first, new value a frame later.
    frame_chk("f6", {S_1, S_1, S_1, S_1}, 4'hF, 1'b1, 1'b0, 16'h0);
    value = 16'h9999;
    dp_in = 4'b0001;
    load  = 1'b1;
    frame_chk("f7", {S_9, S_9, S_9, S_9}, 4'hF, 1'b1, 1'b0, 16'h0);

    // Mask digit 2; digit 0 has its decimal point.
    blank_mask = 4'b0100;
    frame_chk("f8", {S_9, S_OFF, S_9, S_9}, 4'b1110, 1'b1, 1'b0, 16'h0);
    blank_mask = 4'h0;
    dp_in      = 4'h0;

    // Reset in the middle of digit 2's slot.
    repeat (9) step();
    chk("pre-rst an", 32'(an), 32'hB);
    chk("pre-rst seg", 32'(seg), 32'(S_9));
    rst = 1'b1;
    #1;
    chk("mid-rst an", 32'(an), 32'hF);
    chk("mid-rst seg", 32'(seg), 32'(S_OFF));
    chk("mid-rst dp", 32'(dp), 32'h1);
    chk("mid-rst frame_done", 32'(frame_done), 32'h0);
    step();
    rst = 1'b0;

    // Pending data is lost: two frames of zeros.
    frame_chk("f9", {S_0, S_0, S_0, S_0}, 4'hF, 1'b0, 1'b0, 16'h0);
    frame_chk("f10", {S_0, S_0, S_0, S_0}, 4'hF, 1'b1, 1'b0, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sseg_scan_driver.md
Name: sseg_scan_driver

Overview:
Parametrised, time-multiplexed hexadecimal driver for N common-anode seven-segment digits. It is the multi-digit successor to the single-digit hex decoder. A free-running prescaler scans the digits one at a time. Each digit gets a guard (all-off) cycle to suppress ghosting. A shadow register commits new values only at frame boundaries, so no digit ever shows a torn value. Leading-zero blanking and per-digit masking are supported. The block sits between datapath/result registers and the board HEX/anode pins.

Parameters:
N_DIGITS, 4, number of digits scanned (1..8)
DIV, 50000, clk cycles per digit slot (>=2)
SEG_ACTIVE_LOW, 1, 1: segment lit = 0; 0: segment lit = 1
AN_ACTIVE_LOW, 1, 1: digit enabled = 0; 0: digit enabled = 1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
value  in  4*N_DIGITS  hex nibbles; nibble i = bits [4i+3:4i]; digit 0 is least significant
dp_in  in  N_DIGITS  decimal point request per digit
load  in  1  capture value/dp_in into the pending register
blank_mask  in  N_DIGITS  1 = force digit i blank; live, not latched
lz_en  in  1  leading-zero blanking enable; live
seg  out  7  segments {g,f,e,d,c,b,a}, registered
dp  out  1  decimal point, registered
an  out  N_DIGITS  one-hot digit enable, registered
frame_done  out  1  one-cycle pulse per completed frame

Behaviour:
- Reset (async, rst=1):
  - cnt=0, idx=0, pending=0, display=0, dp registers=0.
  - seg/dp/an all inactive: seg=7'h7F and an=all 1s when both are active-low.
  - frame_done=0.
- Prescaler: cnt counts 0..DIV-1 and wraps. tick = (cnt==DIV-1).
- Digit index: on a tick edge, idx <= (idx==N_DIGITS-1) ? 0 : idx+1.
- Slot timing:
  - Outputs are registered from the state after each edge.
  - In cycles where the registered cnt==0 (guard cycle), an and seg/dp are all inactive.
  - In cycles where cnt is 1..DIV-1, an enables digit idx only, and seg/dp show that digit.
  - Each digit is therefore lit DIV-1 of every DIV cycles.
  - After reset, the first lit cycle (digit 0) is at cnt==1.
- Pending/commit:
  - load=1 at an edge: pending <= {value, dp_in}.
  - display <= pending at the tick edge where idx==N_DIGITS-1, i.e. the frame wrap.
  - If load coincides with the commit edge, display takes the old pending. The new data commits one frame later.
  - Successive loads within a frame: only the last one is kept.
- frame_done: registered, high for exactly the one cycle following the commit edge.
- Decode, active-high lit pattern {g..a}:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=67, A=77, b=7C, C=58, d=5E, E=7B, F=71
  - Active-low output is the bitwise inverse: 0 -> 7'b1000000, F -> 7'b0001110.
- Blanking: digit i is blank if either condition holds:
  - blank_mask[i]=1, or
  - lz_en=1 and i!=0 and display nibbles i..N_DIGITS-1 are all zero.
  - A blank digit outputs seg all-unlit and dp unlit. an is still asserted for its slot, which keeps brightness uniform.
  - Digit 0 is never blanked by lz_en, so value 0 shows "0".
- Width/polarity: the only polarity transform is the output inversion for SEG_ACTIVE_LOW/AN_ACTIVE_LOW. Internal logic is active-high.
- N_DIGITS=1: idx stays 0, every tick is a frame wrap, and the guard cycle still applies.
- Reset mid-frame: everything returns to reset values immediately. Pending data is lost.

Test Plan (N_DIGITS=4, DIV=4, both active-low):
1. Reset released, no load -> an=4'b1111 and seg=7'h7F in every guard cycle. Digits 0..3 each show seg=7'b1000000 for 3 cycles; an pattern is 1110,1101,1011,0111. frame_done pulses every 16 cycles.
2. load with value=16'h1A2F, then wait for the frame wrap -> from the next frame, digit0=F(0001110), digit1=2(0100100), digit2=A(0001000), digit3=1(1111001). No digit changes before the wrap.
3. value=16'h0005, lz_en=1 -> digits 3,2,1 have seg=7'h7F with an still asserted; digit0=5(0010010). Then set lz_en=0 -> digits 3..1 show "0".
4. load asserted on exactly the commit edge with 16'h9999 while pending=16'h1111 -> the frame after shows 1111. The frame after that shows 9999.
5. blank_mask=4'b0100, dp_in=4'b0001 loaded -> digit2 is blank; digit0 has dp=0 (lit); the other digits have dp=1.
6. Assert rst mid-slot of digit 2 -> the same cycle shows an=1111, seg=7F, frame_done=0. After release, the display shows "0000" again starting from digit 0.
